io_port_ctrl: RTL

IO_PORT_CTRL -- requirements
Module: io_port_ctrl

---
 rtl/io_port_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/io_port_ctrl.sv
// rtl/io_port_ctrl.sv - memory-mapped push-button / switch / LED port controller
module io_port_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam logic [23:0] CNT_MAX = 24'(DEBOUNCE_CYCLES - 1);

    logic        sync_a;
    logic        sync_b;
    logic        state;
    logic [23:0] cnt;

    // press fires in the same edge that accepts a debounced rising edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            state  <= 1'b0;
            cnt    <= 24'd0;
            press  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b != state) begin
                if (cnt == CNT_MAX) begin
                    state <= sync_b;
                    cnt   <= 24'd0;
                    press <= sync_b;
                end else begin
                    cnt <= cnt + 24'd1;
                end
            end else begin
                cnt <= 24'd0;
            end
        end
    end
endmodule

module io_port_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pRead,
    input  logic        pWrite,
    input  logic [1:0]  addr,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    input  logic        btnL,
    input  logic        btnR,
    input  logic [15:0] switch,
    output logic [11:0] led
);
    logic        press_l;
    logic        press_r;
    logic [15:0] sw_sync_a;
    logic [15:0] sw_sync_b;
    logic [15:0] sw_reg;
    logic        sw_ready;
    logic        led_ready;
    logic        unused_wdata;

    assign unused_wdata = ^writeData[31:12];

    io_port_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk   (clk),
        .reset (reset),
        .raw   (btnL),
        .press (press_l)
    );

    io_port_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk   (clk),
        .reset (reset),
        .raw   (btnR),
        .press (press_r)
    );

    // button presses take priority over CPU acknowledges in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_sync_a <= 16'd0;
            sw_sync_b <= 16'd0;
            sw_reg    <= 16'd0;
            sw_ready  <= 1'b0;
            led       <= 12'd0;
            led_ready <= 1'b1;
        end else begin
            sw_sync_a <= switch;
            sw_sync_b <= sw_sync_a;
            if (press_r) begin
                sw_reg   <= sw_sync_b;
                sw_ready <= 1'b1;
            end else if (pWrite && addr == 2'b00 && writeData[0]) begin
                sw_ready <= 1'b0;
            end
            if (pWrite && addr == 2'b11) begin
                led <= writeData[11:0];
            end
            if (press_l) begin
                led_ready <= 1'b1;
            end else if (pWrite && addr == 2'b11) begin
                led_ready <= 1'b0;
            end
        end
    end

    always_comb begin
        readData = 32'd0;
        if (pRead) begin
            case (addr)
                2'b00: readData = {30'd0, led_ready, sw_ready};
                2'b01: readData = {24'd0, sw_reg[15:8]};
                2'b10: readData = {24'd0, sw_reg[7:0]};
                default: readData = {20'd0, led};
            endcase
        end
    end
endmodule
